// File: rtl/switch_sel_pkg.sv
// Shared constants and types for the switch-select debounce controller:
// register map, per-bit debounce state encoding and edge qualification modes.
package switch_sel_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_PERIOD  = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } deb_state_e;

    // A period of zero is treated like one: the count still spends one cycle in COUNT.
    function automatic logic [31:0] period_load(input logic [31:0] period);
        return (period == 32'd0) ? 32'd0 : period - 32'd1;
    endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch input: 2-flop synchronizer, debounce FSM with a 32-bit down-counter,
// and a single-cycle qualified edge pulse issued when the debounced level changes.
module switch_debounce_bit
    import switch_sel_pkg::*;
#(
    parameter int EDGE_TYPE = EDGE_ANY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] period,
    input  logic        raw_in,
    output logic        level,
    output logic        edge_pulse
);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        level_q, level_d;
    logic [31:0] cnt_q, cnt_d;
    deb_state_e  state_q, state_d;

    always_comb begin
        sync1_d    = raw_in;
        sync2_d    = sync1_q;
        level_d    = level_q;
        cnt_d      = cnt_q;
        state_d    = state_q;
        edge_pulse = 1'b0;
        case (state_q)
            STABLE: begin
                if (sync2_q != level_q) begin
                    cnt_d   = period_load(period);
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (sync2_q == level_q) begin
                    state_d = STABLE;
                end else if (cnt_q == 32'd0) begin
                    level_d    = sync2_q;
                    state_d    = STABLE;
                    edge_pulse = (EDGE_TYPE == EDGE_RISING)  ? sync2_q :
                                 (EDGE_TYPE == EDGE_FALLING) ? ~sync2_q : 1'b1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= 32'd0;
            state_q <= STABLE;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/switch_sel_debounce_ctrl.sv
// Avalon-MM slave wrapping WIDTH debounced switch inputs: DATA, PERIOD, IRQMASK and
// sticky EDGECAPTURE registers with a registered read mux and a registered level irq.
module switch_sel_debounce_ctrl
    import switch_sel_pkg::*;
#(
    parameter int          WIDTH          = 1,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd50000,
    parameter int          EDGE_TYPE      = EDGE_ANY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] edge_pulse;
    logic [31:0]      period_q, period_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             wr_en;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            switch_debounce_bit #(
                .EDGE_TYPE (EDGE_TYPE)
            ) u_bit (
                .clk        (clk),
                .reset      (reset),
                .period     (period_q),
                .raw_in     (in_port[gi]),
                .level      (level[gi]),
                .edge_pulse (edge_pulse[gi])
            );
        end
    endgenerate

    assign wr_en = chipselect & ~write_n;

    always_comb begin
        period_d  = period_q;
        irqmask_d = irqmask_q;
        w1c       = '0;
        if (wr_en && address == ADDR_PERIOD)  period_d  = writedata;
        if (wr_en && address == ADDR_IRQMASK) irqmask_d = writedata[WIDTH-1:0];
        if (wr_en && address == ADDR_EDGECAP) w1c       = writedata[WIDTH-1:0];
        // A new qualified edge wins over a clear landing in the same cycle.
        edgecap_d = (edgecap_q & ~w1c) | edge_pulse;
        irq_d     = |(edgecap_q & irqmask_q);

        readdata_d = '0;
        case (address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = level;
            ADDR_PERIOD:  readdata_d            = period_q;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period_q   <= DEFAULT_PERIOD;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            period_q   <= period_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_switch_sel_debounce_ctrl.sv
// Self-checking bench: an any-edge and a rising-only instance share one bus; reads go
// through a scoreboard queue and every comparison goes through chk.
module tb_switch_sel_debounce_ctrl;
    import switch_sel_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port_a, in_port_b;
    logic [31:0] readdata_a, readdata_b;
    logic        irq_a, irq_b;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } rd_exp_t;
    rd_exp_t sb_q[$];

    always #5 clk = ~clk;

    switch_sel_debounce_ctrl #(
        .WIDTH(4), .DEFAULT_PERIOD(32'd4), .EDGE_TYPE(EDGE_ANY)
    ) u_dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port_a),
        .readdata(readdata_a), .irq(irq_a)
    );

    switch_sel_debounce_ctrl #(
        .WIDTH(4), .DEFAULT_PERIOD(32'd4), .EDGE_TYPE(EDGE_RISING)
    ) u_dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port_b),
        .readdata(readdata_b), .irq(irq_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, obs);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Observes the register value present now; compared one clock later.
    task automatic rd(input int sel, input logic [1:0] addr, input logic [31:0] exp,
                      input string tag);
        rd_exp_t e;
        rd_exp_t got;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        address = addr;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got = sb_q.pop_front();
        chk(got.tag, (got.sel == 1) ? readdata_b : readdata_a, got.exp);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        address    = ADDR_DATA;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port_a  = 4'b0001;
        in_port_b  = 4'b0000;
        @(negedge clk);
        cyc(3);
        chk("reset_readdata", readdata_a, 32'h0);
        chk("reset_irq", {31'b0, irq_a}, 32'h0);

        // Release with bit 0 already high: DATA rises 2+1+4 edges later.
        reset = 1'b0;
        cyc(1);
        rd(0, ADDR_PERIOD,  32'd4, "reset_period");
        rd(0, ADDR_IRQMASK, 32'd0, "reset_irqmask");
        rd(0, ADDR_EDGECAP, 32'd0, "reset_edgecap");
        for (int k = 4; k <= 10; k++)
            rd(0, ADDR_DATA, (k >= 7) ? 32'h1 : 32'h0, $sformatf("data_after_edge%0d", k));
        rd(0, ADDR_EDGECAP, 32'h1, "edgecap_after_reset_rise");
        chk("irq_masked", {31'b0, irq_a}, 32'h0);

        wr(ADDR_EDGECAP, 32'h1);
        rd(0, ADDR_EDGECAP, 32'h0, "edgecap_w1c");

        // Glitch shorter than the period is rejected.
        wr(ADDR_PERIOD, 32'd8);
        in_port_a[1] = 1'b1;
        cyc(3);
        in_port_a[1] = 1'b0;
        cyc(20);
        rd(0, ADDR_DATA,    32'h1, "glitch_data");
        rd(0, ADDR_EDGECAP, 32'h0, "glitch_edgecap");

        // Masked clean rising step: edgecap at edge 11, irq at edge 12.
        wr(ADDR_IRQMASK, 32'hFFFF_FFFF);
        rd(0, ADDR_IRQMASK, 32'hF, "irqmask_upper_ignored");
        in_port_a[1] = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            cyc(1);
            chk($sformatf("irq_after_edge%0d", k), {31'b0, irq_a}, (k >= 12) ? 32'h1 : 32'h0);
        end
        rd(0, ADDR_EDGECAP, 32'h2, "edgecap_bit1");
        wr(ADDR_EDGECAP, 32'h2);
        chk("irq_still_set_at_clear", {31'b0, irq_a}, 32'h1);
        cyc(1);
        chk("irq_cleared", {31'b0, irq_a}, 32'h0);
        rd(0, ADDR_EDGECAP, 32'h0, "edgecap_cleared");

        // W1C landing on the same edge as a new qualified edge: set wins.
        in_port_a[2] = 1'b1;
        cyc(10);
        wr(ADDR_EDGECAP, 32'h4);
        rd(0, ADDR_EDGECAP, 32'h4, "edgecap_set_wins");
        chk("irq_set_wins", {31'b0, irq_a}, 32'h1);
        wr(ADDR_EDGECAP, 32'h4);
        rd(0, ADDR_EDGECAP, 32'h0, "edgecap_cleared2");

        // PERIOD rewrite mid-count leaves the running count at 100.
        wr(ADDR_PERIOD, 32'd100);
        in_port_a[3] = 1'b1;
        cyc(20);
        wr(ADDR_PERIOD, 32'd2);
        cyc(81);
        rd(0, ADDR_DATA, 32'h7, "period_old_edge102");
        rd(0, ADDR_DATA, 32'hF, "period_old_edge103");
        in_port_a[3] = 1'b0;
        cyc(4);
        rd(0, ADDR_DATA, 32'hF, "period_new_edge4");
        rd(0, ADDR_DATA, 32'h7, "period_new_edge5");
        rd(0, ADDR_EDGECAP, 32'h8, "edgecap_falling_any");
        rd(0, ADDR_PERIOD, 32'd2, "period_readback");

        // Rising-only instance: rises capture, a fall does not.
        in_port_b = 4'b1111;
        cyc(10);
        rd(1, ADDR_DATA,    32'hF, "b_data_all_high");
        rd(1, ADDR_EDGECAP, 32'hF, "b_edgecap_rising");
        chk("b_irq_set", {31'b0, irq_b}, 32'h1);
        wr(ADDR_EDGECAP, 32'hF);
        cyc(2);
        chk("b_irq_cleared", {31'b0, irq_b}, 32'h0);
        in_port_b = 4'b1011;
        cyc(10);
        rd(1, ADDR_DATA,    32'h0000000B, "b_data_bit2_low");
        rd(1, ADDR_EDGECAP, 32'h0, "b_edgecap_no_fall");
        chk("b_irq_no_fall", {31'b0, irq_b}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
